// File: rtl/avalon_add_master_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | avalon_add_master_pkg: adder-slave register map and master FSM states |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package avalon_add_master_pkg;

  localparam int unsigned ADDR_OP_A = 0;
  localparam int unsigned ADDR_OP_B = 1;
  localparam int unsigned ADDR_SUM  = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_A    = 3'd1,
    S_WR_B    = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/avalon_add_master_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | avalon_add_master_if: command/response ports plus Avalon-MM bus       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface avalon_add_master_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_timeout;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic              avm_read;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_waitrequest;
  logic              avm_readdatavalid;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, rsp_ready,
           avm_readdata, avm_waitrequest, avm_readdatavalid,
    output cmd_ready, rsp_valid, rsp_data, rsp_timeout,
           avm_address, avm_write, avm_writedata, avm_read
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, rsp_ready,
           avm_readdata, avm_waitrequest, avm_readdatavalid,
    input  cmd_ready, rsp_valid, rsp_data, rsp_timeout,
           avm_address, avm_write, avm_writedata, avm_read
  );
endinterface
`default_nettype wire

// File: rtl/avalon_add_master_avm_rd_wait_ctr.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | avm_rd_wait_ctr: read-data capture timing and timeout detection       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module avm_rd_wait_ctr
  import avalon_add_master_pkg::*;
#(
  parameter int USE_RDVALID = 0,
  parameter int RD_LATENCY  = 1,
  parameter int TIMEOUT     = 255
) (
  input  wire logic clock,
  input  wire logic reset,
  input  wire logic active,
  input  wire logic rdvalid,
  output logic      capture,
  output logic      timeout
);
  localparam int CNT_MAX = max_int(TIMEOUT, RD_LATENCY);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [CNT_W-1:0] cnt;
  logic             lat_hit;

  // Counter holds at zero outside the wait window so each read starts fresh.
  always_ff @(posedge clock) begin
    if (reset || !active) begin
      cnt <= '0;
    end else if (cnt != CNT_W'(CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    lat_hit = (cnt == CNT_W'(RD_LATENCY - 1));
    capture = active && ((USE_RDVALID != 0) ? rdvalid : lat_hit);
    timeout = active && !capture && (cnt == CNT_W'(TIMEOUT - 1));
  end

endmodule
`default_nettype wire

// File: rtl/avalon_add_master.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | avalon_add_master: writes A/B to the adder slave, reads back the sum  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module avalon_add_master
  import avalon_add_master_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 3,
  parameter int USE_RDVALID = 0,
  parameter int RD_LATENCY  = 1,
  parameter int TIMEOUT     = 255
) (
  input wire logic            clock,
  input wire logic            reset,
  avalon_add_master_if.master bus
);
  state_t            state, state_nxt;
  logic [DATA_W-1:0] op_a, op_b;
  logic [DATA_W-1:0] sum_q;
  logic              timeout_q;
  logic              rd_capture;
  logic              rd_timeout;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_a <= '0;
      op_b <= '0;
    end else if (state == S_IDLE && bus.cmd_valid) begin
      op_a <= bus.cmd_a;
      op_b <= bus.cmd_b;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sum_q     <= '0;
      timeout_q <= 1'b0;
    end else if (rd_capture) begin
      sum_q     <= bus.avm_readdata;
      timeout_q <= 1'b0;
    end else if (rd_timeout) begin
      sum_q     <= '0;
      timeout_q <= 1'b1;
    end
  end

  avm_rd_wait_ctr #(
    .USE_RDVALID (USE_RDVALID),
    .RD_LATENCY  (RD_LATENCY),
    .TIMEOUT     (TIMEOUT)
  ) u_rd_wait_ctr (
    .clock   (clock),
    .reset   (reset),
    .active  (state == S_RD_WAIT),
    .rdvalid (bus.avm_readdatavalid),
    .capture (rd_capture),
    .timeout (rd_timeout)
  );

  // Bus outputs decode from state and latched operands only, so they stay
  // stable for as long as the slave stalls.
  always_comb begin
    state_nxt         = state;
    bus.cmd_ready     = 1'b0;
    bus.rsp_valid     = 1'b0;
    bus.avm_address   = '0;
    bus.avm_write     = 1'b0;
    bus.avm_writedata = '0;
    bus.avm_read      = 1'b0;
    case (state)
      S_IDLE: begin
        bus.cmd_ready = !reset;
        if (bus.cmd_valid) state_nxt = S_WR_A;
      end
      S_WR_A: begin
        bus.avm_write     = 1'b1;
        bus.avm_address   = ADDR_W'(ADDR_OP_A);
        bus.avm_writedata = op_a;
        if (!bus.avm_waitrequest) state_nxt = S_WR_B;
      end
      S_WR_B: begin
        bus.avm_write     = 1'b1;
        bus.avm_address   = ADDR_W'(ADDR_OP_B);
        bus.avm_writedata = op_b;
        if (!bus.avm_waitrequest) state_nxt = S_RD_REQ;
      end
      S_RD_REQ: begin
        bus.avm_read    = 1'b1;
        bus.avm_address = ADDR_W'(ADDR_SUM);
        if (!bus.avm_waitrequest) state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (rd_capture || rd_timeout) state_nxt = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.rsp_data    = sum_q;
  assign bus.rsp_timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_avalon_add_master.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_avalon_add_master: adder-slave models with a response scoreboard   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_avalon_add_master;

  typedef struct {
    logic [31:0] data;
    logic        to;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          ws;
    logic [31:0] sum;
    int          lat;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic        rsp_ready = 1'b0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];

  always #5 clock = ~clock;

  avalon_add_master_if #(.DATA_W(32), .ADDR_W(3)) ifa ();
  avalon_add_master_if #(.DATA_W(32), .ADDR_W(3)) ifb ();

  avalon_add_master #(.DATA_W(32), .ADDR_W(3), .USE_RDVALID(0), .RD_LATENCY(1), .TIMEOUT(255))
    dut_a (.clock(clock), .reset(reset), .bus(ifa));
  avalon_add_master #(.DATA_W(32), .ADDR_W(3), .USE_RDVALID(1), .RD_LATENCY(1), .TIMEOUT(8))
    dut_b (.clock(clock), .reset(reset), .bus(ifb));

  assign ifa.cmd_valid = cmd_valid && !sel;
  assign ifb.cmd_valid = cmd_valid && sel;
  assign ifa.cmd_a = cmd_a;
  assign ifb.cmd_a = cmd_a;
  assign ifa.cmd_b = cmd_b;
  assign ifb.cmd_b = cmd_b;
  assign ifa.rsp_ready = rsp_ready && !sel;
  assign ifb.rsp_ready = rsp_ready && sel;

  wire        w_ready = sel ? ifb.cmd_ready   : ifa.cmd_ready;
  wire        w_rv    = sel ? ifb.rsp_valid   : ifa.rsp_valid;
  wire [31:0] w_rdata = sel ? ifb.rsp_data    : ifa.rsp_data;
  wire        w_rto   = sel ? ifb.rsp_timeout : ifa.rsp_timeout;

  // Slave A: registered readdata, configurable waitrequest per access
  int          ws_cfg = 0;
  int          stall_cnt = 0;
  logic [31:0] reg_a = '0, reg_b = '0, rd_q = '0;
  logic [2:0]  last_rd_addr = '0;
  assign ifa.avm_waitrequest   = (ifa.avm_write || ifa.avm_read) && (stall_cnt < ws_cfg);
  assign ifa.avm_readdata      = rd_q;
  assign ifa.avm_readdatavalid = 1'b0;

  always @(posedge clock) begin
    if ((ifa.avm_write || ifa.avm_read) && !ifa.avm_waitrequest) stall_cnt <= 0;
    else if (ifa.avm_write || ifa.avm_read)                     stall_cnt <= stall_cnt + 1;
    else                                                        stall_cnt <= 0;
    if (ifa.avm_write && !ifa.avm_waitrequest) begin
      if (ifa.avm_address == 3'd0) reg_a <= ifa.avm_writedata;
      if (ifa.avm_address == 3'd1) reg_b <= ifa.avm_writedata;
    end
    if (ifa.avm_read && !ifa.avm_waitrequest) begin
      rd_q         <= (ifa.avm_address == 3'd3) ? reg_a + reg_b : 32'hDEAD_BEEF;
      last_rd_addr <= ifa.avm_address;
    end
  end

  // Slave B: readdatavalid strobe a programmable number of cycles after read
  int          rdv_delay = 1000;
  int          dly = 0;
  logic        pend = 1'b0;
  logic [31:0] rb_a = '0, rb_b = '0;
  assign ifb.avm_waitrequest   = 1'b0;
  assign ifb.avm_readdata      = rb_a + rb_b;
  assign ifb.avm_readdatavalid = pend && (dly == rdv_delay);

  always @(posedge clock) begin
    if (ifb.avm_write && ifb.avm_address == 3'd0) rb_a <= ifb.avm_writedata;
    if (ifb.avm_write && ifb.avm_address == 3'd1) rb_b <= ifb.avm_writedata;
    if (ifb.avm_read) begin
      pend <= 1'b1;
      dly  <= 0;
    end else if (pend) begin
      if (dly == rdv_delay) pend <= 1'b0;
      else                  dly  <= dly + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus must not move while the slave stalls; write and read never overlap.
  logic       prev_stall = 1'b0;
  logic [2:0] s_addr = '0;
  logic       s_wr = 1'b0, s_rd = 1'b0;
  logic [31:0] s_wd = '0;
  always @(negedge clock) begin
    if (!reset) begin
      chk("wr_rd_excl_a", ifa.avm_write & ifa.avm_read, 0);
      chk("wr_rd_excl_b", ifb.avm_write & ifb.avm_read, 0);
      if (prev_stall) begin
        chk("stall_addr", ifa.avm_address, s_addr);
        chk("stall_wr", ifa.avm_write, s_wr);
        chk("stall_rd", ifa.avm_read, s_rd);
        chk("stall_wdata", ifa.avm_writedata, s_wd);
      end
    end
    prev_stall <= ifa.avm_waitrequest && !reset;
    s_addr     <= ifa.avm_address;
    s_wr       <= ifa.avm_write;
    s_rd       <= ifa.avm_read;
    s_wd       <= ifa.avm_writedata;
  end

  task automatic pop_cmp(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb: got response, expected none queued", name);
    end else begin
      e = sb.pop_front();
      chk({name, "_data"}, w_rdata, e.data);
      chk({name, "_timeout"}, w_rto, e.to);
    end
  endtask

  // Called at a negedge; leaves on the posedge that accepts the command.
  task automatic send_cmd(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_d, input logic exp_to, input bit hold);
    int n = 0;
    cmd_a = a;
    cmd_b = b;
    cmd_valid = 1'b1;
    sb.push_back('{exp_d, exp_to});
    while (!w_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("cmd_accept", w_ready, 1);
    @(posedge clock);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Latency counts the accept edge as 1 up to the edge raising rsp_valid.
  task automatic get_rsp(input int exp_lat, input string name);
    int lat = 1;
    @(negedge clock);
    while (!w_rv && lat < 300) begin
      @(negedge clock);
      lat++;
    end
    chk({name, "_lat"}, lat, exp_lat);
    if (w_rv) pop_cmp(name);
    else if (sb.size() != 0) void'(sb.pop_front());
    rsp_ready = 1'b1;
    @(posedge clock);
    #1 rsp_ready = 1'b0;
    @(negedge clock);
    chk({name, "_drop"}, w_rv, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   lat;
    vecs[0] = '{32'd5,        32'd7,        0, 32'd12,   5};
    vecs[1] = '{32'hFFFF_FFFF, 32'd2,       0, 32'd1,    5};
    vecs[2] = '{32'd1234,     32'd4321,     3, 32'd5555, 14};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1, 32'd0,  8};
    vecs[4] = '{32'd0,        32'd0,        0, 32'd0,    5};

    repeat (3) @(negedge clock);
    chk("rst_cmd_ready", ifa.cmd_ready, 0);
    chk("rst_rsp_valid", ifa.rsp_valid, 0);
    chk("rst_rsp_timeout", ifa.rsp_timeout, 0);
    chk("rst_rsp_data", ifa.rsp_data, 0);
    chk("rst_write", ifa.avm_write, 0);
    chk("rst_read", ifa.avm_read, 0);
    chk("rst_address", ifa.avm_address, 0);
    chk("rst_writedata", ifa.avm_writedata, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_ready", ifa.cmd_ready, 1);

    for (int i = 0; i < 5; i++) begin
      ws_cfg = vecs[i].ws;
      send_cmd(vecs[i].a, vecs[i].b, vecs[i].sum, 1'b0, 1'b0);
      get_rsp(vecs[i].lat, $sformatf("vec%0d", i));
      if (i == 0) begin
        chk("slave_reg_a", reg_a, 5);
        chk("slave_reg_b", reg_b, 7);
        chk("slave_rd_addr", last_rd_addr, 3);
      end
    end
    ws_cfg = 0;

    // Response back-pressure with the next command already waiting
    send_cmd(32'd3, 32'd4, 32'd7, 1'b0, 1'b1);
    cmd_a = 32'd10;
    cmd_b = 32'd20;
    lat = 1;
    @(negedge clock);
    while (!w_rv && lat < 50) begin
      chk("busy_ready", w_ready, 0);
      @(negedge clock);
      lat++;
    end
    chk("hold_lat", lat, 5);
    repeat (4) begin
      chk("hold_valid", w_rv, 1);
      chk("hold_data", w_rdata, 7);
      chk("hold_to", w_rto, 0);
      chk("hold_ready", w_ready, 0);
      @(negedge clock);
    end
    pop_cmp("hold");
    rsp_ready = 1'b1;
    sb.push_back('{32'd30, 1'b0});
    @(posedge clock);
    #1 rsp_ready = 1'b0;
    @(negedge clock);
    chk("ready_after_rsp", w_ready, 1);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    get_rsp(5, "held_cmd");

    // Reset while the second write is on the bus
    cmd_a = 32'd9;
    cmd_b = 32'd9;
    cmd_valid = 1'b1;
    chk("mid_accept", w_ready, 1);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("wrb_write", ifa.avm_write, 1);
    chk("wrb_addr", ifa.avm_address, 1);
    chk("wrb_data", ifa.avm_writedata, 9);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_write", ifa.avm_write, 0);
    chk("mid_rst_read", ifa.avm_read, 0);
    chk("mid_rst_valid", ifa.rsp_valid, 0);
    chk("mid_rst_ready", ifa.cmd_ready, 0);
    reset = 1'b0;
    repeat (8) begin
      @(negedge clock);
      chk("no_rsp", ifa.rsp_valid, 0);
    end
    send_cmd(32'd100, 32'd23, 32'd123, 1'b0, 1'b0);
    get_rsp(5, "post_mid_rst");

    // Readdatavalid-driven capture, then a read that never returns
    sel = 1'b1;
    @(negedge clock);
    rdv_delay = 2;
    send_cmd(32'd40, 32'd2, 32'd42, 1'b0, 1'b0);
    get_rsp(7, "rdvalid");
    rdv_delay = 1000;
    send_cmd(32'd1, 32'd1, 32'd0, 1'b1, 1'b0);
    get_rsp(12, "timeout");
    send_cmd(32'd6, 32'd6, 32'd0, 1'b1, 1'b0);
    get_rsp(12, "timeout2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
